// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Bits needed to index 'value' distinct items (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int DEFAULT_DIV = calc_div(1_000_000, 100_000);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; head word is presented
// combinationally so the consumer can capture it on the pop edge.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, configurable width/stop bits.
// Define UART_TX_PARITY_EN to add a parity bit selected by parity_odd.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 1_000_000,
  parameter int BAUD       = 100_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       parity_odd,
  output logic                       tx,
  output logic                       busy,
  output logic [clog2(FIFO_DEPTH):0] level
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = clog2(DIV);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DIV < 2 || (CLK_HZ % BAUD) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo: illegal parameter combination");
  end

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     baud_cnt_reg, baud_cnt_next;
  logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_reg, tx_next;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity_reg, parity_next;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (level)
  );

  assign bit_end  = (baud_cnt_reg == BAUD_LAST);
  assign in_ready = !fifo_full;
  assign busy     = (state_reg != IDLE) || !fifo_empty;
  assign tx       = tx_reg;

  // tx_next reflects the current state, so the line lags the FSM by one clock.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = 1'b1;
    fifo_pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    if (state_reg != IDLE) baud_cnt_next = bit_end ? '0 : baud_cnt_reg + CNT_W'(1);
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          shift_next    = fifo_head;
          baud_cnt_next = '0;
          state_next    = START;
`ifdef UART_TX_PARITY_EN
          parity_next   = (^fifo_head) ^ parity_odd;
`endif
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == DATA_LAST) begin
            bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_reg;
        if (bit_end) begin
          state_next   = STOP;
          bit_idx_next = '0;
        end
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (bit_idx_reg == STOP_LAST) state_next = IDLE;
          else bit_idx_next = bit_idx_reg + IDX_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: an 8N1 instance and a 7-bit/2-stop instance,
// checked against a frame-level reference model (bit lists, start-time rule, word queue).
module tb_uart_tx_fifo;

  localparam int DIV   = 10;
  localparam int DB1   = 8;
  localparam int SB1   = 1;
  localparam int DB2   = 7;
  localparam int SB2   = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L1 = (1 + DB1 + PAR + SB1) * DIV;
  localparam int L2 = (1 + DB2 + PAR + SB2) * DIV;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_data2;
  logic       in_valid2;
  logic       in_ready2;
  logic       parity_odd;
  logic       tx, busy, tx2, busy2;
  logic [2:0] level, level2;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(DB1), .STOP_BITS(SB1), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .parity_odd(parity_odd), .tx(tx), .busy(busy), .level(level)
  );

  uart_tx_fifo #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(DB2), .STOP_BITS(SB2), .FIFO_DEPTH(DEPTH)
  ) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .parity_odd(parity_odd), .tx(tx2), .busy(busy2), .level(level2)
  );

  function automatic logic sel_tx(input int which);
    return (which != 0) ? tx2 : tx;
  endfunction

  // Reference frame: start 0, data LSB-first, optional parity, stop 1s; one entry per bit period.
  function automatic logic [15:0] frame_bits(input int which, input logic [8:0] word, input logic odd);
    int          db, sb, pos;
    logic [15:0] b;
    logic [8:0]  m;
    db  = (which != 0) ? DB2 : DB1;
    sb  = (which != 0) ? SB2 : SB1;
    m   = 9'((1 << db) - 1);
    b   = '0;
    pos = 1;
    for (int i = 0; i < db; i++) begin b[pos] = word[i]; pos++; end
    if (PAR != 0) begin b[pos] = (^(word & m)) ^ odd; pos++; end
    for (int s = 0; s < sb; s++) begin b[pos] = 1'b1; pos++; end
    return b;
  endfunction

  // Offers one word and returns the edge number at which it was accepted (-1 on timeout).
  task automatic push_word(input int which, input logic [8:0] w, output int edge_no);
    logic rdy;
    edge_no = -1;
    if (which != 0) begin in_data2 = w[6:0]; in_valid2 = 1'b1; end
    else begin in_data = w[7:0]; in_valid = 1'b1; end
    for (int t = 0; t < 2000; t++) begin
      rdy = (which != 0) ? in_ready2 : in_ready;
      @(posedge clk); #1;
      if (rdy) begin edge_no = cyc; break; end
    end
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  // Waits for a start bit, then records each bit period's value and whether it held for DIV clocks.
  task automatic capture_frame(input int which, output int fall, output logic [15:0] bits,
                               output logic stable);
    int nb;
    nb     = 1 + ((which != 0) ? DB2 : DB1) + PAR + ((which != 0) ? SB2 : SB1);
    fall   = -1;
    bits   = '0;
    stable = 1'b0;
    for (int t = 0; t < 600; t++) begin
      if (sel_tx(which) === 1'b0) begin fall = cyc; break; end
      @(posedge clk); #1;
    end
    if (fall < 0) return;
    stable = 1'b1;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < DIV; k++) begin
        if (i != 0 || k != 0) begin @(posedge clk); #1; end
        if (k == 0) bits[i] = sel_tx(which);
        else if (sel_tx(which) !== bits[i]) stable = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (level !== 3'd0)    begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (tx2 !== 1'b1)      begin n_err++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset: tx=%b busy=%b in_ready=%b level=%0d", tx, busy, in_ready, level);
  endtask

  task automatic test_single();
    int e, fall;
    logic [15:0] bits, exp;
    logic st;
    push_word(0, 9'h55, e);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_after_push: got %b want 1", busy); end
    capture_frame(0, fall, bits, st);
    exp = frame_bits(0, 9'h55, parity_odd);
    n_cmp++; if (fall !== e + 2) begin n_err++; $display("FAIL single_latency: start at %0d want %0d", fall, e + 2); end
    n_cmp++; if (bits !== exp)   begin n_err++; $display("FAIL single_bits: got %h want %h", bits, exp); end
    n_cmp++; if (st !== 1'b1)    begin n_err++; $display("FAIL single_stable: bit not held %0d clks", DIV); end
    n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL single_level_end: got %0d want 0", level); end
    $display("single: word 0x55 start=%0d bits=%h", fall, bits);
  endtask

  task automatic test_back_to_back();
    int e1, e2, f1, f2;
    logic [15:0] bits, exp;
    logic st;
    push_word(0, 9'hA3, e1);
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL b2b_level_first: got %0d want 1", level); end
    push_word(0, 9'h0F, e2);
    n_cmp++; if (e2 !== e1 + 1)  begin n_err++; $display("FAIL b2b_accept: edge %0d want %0d", e2, e1 + 1); end
    // second push coincides with the first pop
    n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL b2b_level_pushpop: got %0d want 1", level); end
    capture_frame(0, f1, bits, st);
    exp = frame_bits(0, 9'hA3, parity_odd);
    n_cmp++; if (f1 !== e1 + 2) begin n_err++; $display("FAIL b2b_start1: got %0d want %0d", f1, e1 + 2); end
    n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL b2b_frame1: got %h stable %b want %h", bits, st, exp); end
    capture_frame(0, f2, bits, st);
    exp = frame_bits(0, 9'h0F, parity_odd);
    n_cmp++; if (f2 !== f1 + L1 + 1) begin n_err++; $display("FAIL b2b_gap: start2 %0d want %0d", f2, f1 + L1 + 1); end
    n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL b2b_frame2: got %h stable %b want %h", bits, st, exp); end
    n_cmp++; if (busy !== 1'b0 || level !== 3'd0) begin n_err++; $display("FAIL b2b_end: busy %b level %0d want 0 0", busy, level); end
    $display("back_to_back: starts %0d %0d", f1, f2);
  endtask

  // Random words with random gaps; each start time must be max(push+2, prev_start+L1+1).
  task automatic run_stream(input string name, input int n, input int max_gap, input bit want_full);
    logic [8:0]  wq[$];
    int          eq[$];
    logic [8:0]  w_p, w_c;
    int          e_p, e_c, gap, fall, exp_fall, prev;
    logic [15:0] bits, exp;
    logic        st;
    bit          done;
    int          saw_full, bad_ready;
    done = 1'b0; saw_full = 0; bad_ready = 0; prev = -100000;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
          repeat (gap) begin @(posedge clk); #1; end
          w_p = 9'($urandom_range(0, 255));
          wq.push_back(w_p);
          push_word(0, w_p, e_p);
          eq.push_back(e_p);
        end
      end
      begin
        for (int i = 0; i < n; i++) begin
          capture_frame(0, fall, bits, st);
          if (wq.size() == 0 || eq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_extra_frame: frame at %0d with no word queued", name, fall);
            break;
          end
          w_c = wq.pop_front();
          e_c = eq.pop_front();
          exp_fall = (e_c + 2 > prev + L1 + 1) ? e_c + 2 : prev + L1 + 1;
          exp = frame_bits(0, w_c, parity_odd);
          n_cmp++; if (fall !== exp_fall) begin n_err++; $display("FAIL %s_start%0d: got %0d want %0d", name, i, fall, exp_fall); end
          n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL %s_frame%0d: got %h stable %b want %h", name, i, bits, st, exp); end
          $display("%s: word %0d 0x%02h start=%0d", name, i, w_c, fall);
          prev = fall;
        end
        done = 1'b1;
      end
      begin
        for (int t = 0; t < 20000 && !done; t++) begin
          @(posedge clk); #1;
          if (level == 3'(DEPTH)) begin
            saw_full = 1;
            if (in_ready !== 1'b0) bad_ready++;
          end
        end
      end
    join
    n_cmp++; if (bad_ready !== 0) begin n_err++; $display("FAIL %s_ready_at_full: in_ready high %0d cycles at level %0d", name, bad_ready, DEPTH); end
    if (want_full) begin
      n_cmp++; if (saw_full !== 1) begin n_err++; $display("FAIL %s_reach_full: saw_full %0d want 1", name, saw_full); end
    end
  endtask

  task automatic test_fifo_full();
    run_stream("fifo_full", 6, 0, 1'b1);
  endtask

  task automatic test_random();
    run_stream("random", 10, 150, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int e1, e2, e3, e4, fall, lows;
    logic [8:0] w1, w4;
    logic [15:0] bits, exp;
    logic st;
    w1 = 9'($urandom_range(0, 255)) & 9'h0FB;  // data bit 2 low, so tx is low at frame cycle 34
    push_word(0, w1, e1);
    push_word(0, 9'($urandom_range(0, 255)), e2);
    push_word(0, 9'($urandom_range(0, 255)), e3);
    for (int t = 0; t < 200 && cyc < e1 + 2 + 34; t++) begin @(posedge clk); #1; end
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL rst_mid_before: tx %b want 0", tx); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
    n_cmp++; if (level !== 3'd0)    begin n_err++; $display("FAIL rst_mid_level: got %0d want 0", level); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
    lows = 0;
    for (int t = 0; t < L1; t++) begin @(posedge clk); #1; if (tx !== 1'b1) lows++; end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL rst_mid_discard: tx low %0d cycles want 0", lows); end
    w4 = 9'($urandom_range(0, 255));
    push_word(0, w4, e4);
    capture_frame(0, fall, bits, st);
    exp = frame_bits(0, w4, parity_odd);
    n_cmp++; if (fall !== e4 + 2) begin n_err++; $display("FAIL rst_mid_after_start: got %0d want %0d", fall, e4 + 2); end
    n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL rst_mid_after_frame: got %h stable %b want %h", bits, st, exp); end
    $display("reset_midframe: w1=0x%02h aborted, next 0x%02h start=%0d", w1, w4, fall);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int e, fall;
    logic [15:0] bits, exp;
    logic st;
    for (int odd = 0; odd < 2; odd++) begin
      parity_odd = odd[0];
      push_word(0, 9'h07, e);
      @(posedge clk); #1;
      parity_odd = ~odd[0];  // changed after the pop; the frame must keep the sampled setting
      capture_frame(0, fall, bits, st);
      exp = frame_bits(0, 9'h07, odd[0]);
      n_cmp++; if (bits[9] !== ~odd[0]) begin n_err++; $display("FAIL parity_bit_odd%0d: got %b want %b", odd, bits[9], ~odd[0]); end
      n_cmp++; if (bits !== exp || st !== 1'b1 || fall !== e + 2) begin n_err++; $display("FAIL parity_frame_odd%0d: got %h stable %b start %0d want %h start %0d", odd, bits, st, fall, exp, e + 2); end
      $display("parity: odd=%0d bits=%h", odd, bits);
    end
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_two_stop();
    int e1, e2, f1, f2;
    logic [8:0] w2;
    logic [15:0] bits, exp;
    logic st;
    w2 = 9'($urandom_range(0, 127));
    push_word(1, 9'h07F, e1);
    push_word(1, w2, e2);
    capture_frame(1, f1, bits, st);
    exp = frame_bits(1, 9'h07F, parity_odd);
    n_cmp++; if (f1 !== e1 + 2) begin n_err++; $display("FAIL two_stop_start: got %0d want %0d", f1, e1 + 2); end
    n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL two_stop_frame1: got %h stable %b want %h", bits, st, exp); end
    capture_frame(1, f2, bits, st);
    exp = frame_bits(1, w2, parity_odd);
    n_cmp++; if (f2 !== f1 + L2 + 1) begin n_err++; $display("FAIL two_stop_gap: got %0d want %0d", f2, f1 + L2 + 1); end
    n_cmp++; if (bits !== exp || st !== 1'b1) begin n_err++; $display("FAIL two_stop_frame2: got %h stable %b want %h", bits, st, exp); end
    n_cmp++; if (busy2 !== 1'b0 || level2 !== 3'd0) begin n_err++; $display("FAIL two_stop_end: busy %b level %0d want 0 0", busy2, level2); end
    $display("two_stop: 0x7f start=%0d, 0x%02h start=%0d", f1, w2, f2);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_data2   = '0;
    in_valid2  = 1'b0;
    parity_odd = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_random();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_two_stop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
